// File: rtl/memory_readback.sv
// memory_readback: streams image, conv and dense RAM contents to a host,
// one 32-bit word per valid/ready handshake, started by a command word.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   control_reg          host command (START_CMD starts, ABORT_CMD aborts)
//   image_ram_addr_b     read address shared by image banks 0..3
//   q_image0..3          image bank read data (1-cycle latency)
//   conv_ram_addr_b      conv RAM read address
//   q_conv               conv RAM read data (1-cycle latency)
//   dense_ram_addr_b     read address shared by dense banks 0..3
//   q_dense0..3          dense bank read data (1-cycle latency)
//   readdata, rd_valid   word to host and its valid flag
//   rd_ready             host accepts the presented word
//   busy, done           run in progress / run complete
//
// Optional feature: define READBACK_CHECKSUM_EN to append a final word
// holding the mod-2^32 sum of every word handed to the host in the run.

module memory_readback #(
  parameter int          IMAGE_WORDS = 225,
  parameter int          CONV_BYTES  = 18816,
  parameter int          DENSE_WORDS = 4203,
  parameter logic [31:0] START_CMD   = 32'h0000_0002,
  parameter logic [31:0] ABORT_CMD   = 32'h0000_0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] control_reg,
  output logic [9:0]  image_ram_addr_b,
  input  logic [7:0]  q_image0,
  input  logic [7:0]  q_image1,
  input  logic [7:0]  q_image2,
  input  logic [7:0]  q_image3,
  output logic [14:0] conv_ram_addr_b,
  input  logic [7:0]  q_conv,
  output logic [14:0] dense_ram_addr_b,
  input  logic [7:0]  q_dense0,
  input  logic [7:0]  q_dense1,
  input  logic [7:0]  q_dense2,
  input  logic [7:0]  q_dense3,
  output logic [31:0] readdata,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] SEG_IMG   = 2'd0;
  localparam logic [1:0] SEG_CONV  = 2'd1;
  localparam logic [1:0] SEG_DENSE = 2'd2;
`ifdef READBACK_CHECKSUM_EN
  localparam logic [1:0] SEG_CSUM  = 2'd3;
`endif

  localparam logic [9:0]  IMG_LAST   = 10'(IMAGE_WORDS - 1);
  localparam logic [14:0] CONV_LAST  = 15'(CONV_BYTES - 1);
  localparam logic [14:0] DENSE_LAST = 15'(DENSE_WORDS - 1);

  logic [2:0]  state;
  logic [1:0]  seg;
  logic [9:0]  img_addr;
  logic [14:0] conv_addr;
  logic [14:0] dense_addr;
  logic        seg_last;
  logic [31:0] load_word;
  logic        start;
  logic        abort;

`ifdef READBACK_CHECKSUM_EN
  logic [31:0] csum;
  logic [31:0] csum_next;
  assign csum_next = csum + readdata;
`endif

  assign start = (control_reg == START_CMD);
  assign abort = (control_reg == ABORT_CMD);

  assign image_ram_addr_b = img_addr;
  assign conv_ram_addr_b  = conv_addr;
  assign dense_ram_addr_b = dense_addr;

  assign rd_valid = (state == S_PRESENT);
  assign busy     = (state == S_FETCH) ||
                    (state == S_LOAD) ||
                    (state == S_PRESENT);
  assign done     = (state == S_DONE);

  always_comb begin
    seg_last = 1'b1;
    case (seg)
      SEG_IMG:   seg_last = (img_addr == IMG_LAST);
      SEG_CONV:  seg_last = (conv_addr == CONV_LAST);
      SEG_DENSE: seg_last = (dense_addr == DENSE_LAST);
      default:   seg_last = 1'b1;
    endcase
  end

  always_comb begin
    load_word = 32'h0;
    case (seg)
      SEG_IMG:
        load_word = {q_image0, q_image1, q_image2, q_image3};
      SEG_CONV:
        load_word = {24'h0, q_conv};
      SEG_DENSE:
        load_word = {q_dense0, q_dense1, q_dense2, q_dense3};
      default:
        load_word = 32'h0;
    endcase
  end

  // Addresses only move on a handshake, so the address set up in FETCH
  // is still on the bus in LOAD when the RAM data is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      seg        <= SEG_IMG;
      img_addr   <= '0;
      conv_addr  <= '0;
      dense_addr <= '0;
      readdata   <= '0;
`ifdef READBACK_CHECKSUM_EN
      csum       <= '0;
`endif
    end else if (abort) begin
      state      <= S_IDLE;
      seg        <= SEG_IMG;
      img_addr   <= '0;
      conv_addr  <= '0;
      dense_addr <= '0;
`ifdef READBACK_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_FETCH;
            seg        <= SEG_IMG;
            img_addr   <= '0;
            conv_addr  <= '0;
            dense_addr <= '0;
`ifdef READBACK_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          state    <= S_PRESENT;
          readdata <= load_word;
        end
        S_PRESENT: begin
          if (rd_ready) begin
            state <= S_FETCH;
`ifdef READBACK_CHECKSUM_EN
            if (seg != SEG_CSUM) csum <= csum_next;
`endif
            case (seg)
              SEG_IMG: begin
                if (seg_last) begin
                  img_addr <= '0;
                  seg      <= SEG_CONV;
                end else begin
                  img_addr <= img_addr + 10'd1;
                end
              end
              SEG_CONV: begin
                if (seg_last) begin
                  conv_addr <= '0;
                  seg       <= SEG_DENSE;
                end else begin
                  conv_addr <= conv_addr + 15'd1;
                end
              end
              SEG_DENSE: begin
                if (seg_last) begin
                  dense_addr <= '0;
`ifdef READBACK_CHECKSUM_EN
                  // Checksum word is already known: present it directly.
                  seg        <= SEG_CSUM;
                  state      <= S_PRESENT;
                  readdata   <= csum_next;
`else
                  state      <= S_DONE;
`endif
                end else begin
                  dense_addr <= dense_addr + 15'd1;
                end
              end
              default: state <= S_DONE;
            endcase
          end
        end
        S_DONE: begin
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_readback.sv
// tb_memory_readback: randomized self-checking bench for memory_readback
// against a word-sequence reference model built from RAM contents.

`timescale 1ns/1ps

module tb_memory_readback;

  localparam int IW = 12;
  localparam int CB = 120;
  localparam int DW = 10;
  localparam int ND = IW + CB + DW;
`ifdef READBACK_CHECKSUM_EN
  localparam int NW = ND + 1;
`else
  localparam int NW = ND;
`endif
  localparam logic [31:0] START = 32'h0000_0002;
  localparam logic [31:0] ABORT = 32'h0000_0003;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] control_reg = 32'h0;
  logic [9:0]  image_ram_addr_b;
  logic [7:0]  q_image0, q_image1, q_image2, q_image3;
  logic [14:0] conv_ram_addr_b;
  logic [7:0]  q_conv;
  logic [14:0] dense_ram_addr_b;
  logic [7:0]  q_dense0, q_dense1, q_dense2, q_dense3;
  logic [31:0] readdata;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [7:0] m_img   [4][1024];
  logic [7:0] m_conv  [32768];
  logic [7:0] m_dense [4][32768];

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  memory_readback #(
    .IMAGE_WORDS(IW),
    .CONV_BYTES (CB),
    .DENSE_WORDS(DW),
    .START_CMD  (START),
    .ABORT_CMD  (ABORT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .control_reg     (control_reg),
    .image_ram_addr_b(image_ram_addr_b),
    .q_image0        (q_image0),
    .q_image1        (q_image1),
    .q_image2        (q_image2),
    .q_image3        (q_image3),
    .conv_ram_addr_b (conv_ram_addr_b),
    .q_conv          (q_conv),
    .dense_ram_addr_b(dense_ram_addr_b),
    .q_dense0        (q_dense0),
    .q_dense1        (q_dense1),
    .q_dense2        (q_dense2),
    .q_dense3        (q_dense3),
    .readdata        (readdata),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .busy            (busy),
    .done            (done)
  );

  // Synchronous-read RAM models, one cycle of latency.
  always @(posedge clk) begin
    q_image0 <= m_img[0][image_ram_addr_b];
    q_image1 <= m_img[1][image_ram_addr_b];
    q_image2 <= m_img[2][image_ram_addr_b];
    q_image3 <= m_img[3][image_ram_addr_b];
    q_conv   <= m_conv[conv_ram_addr_b];
    q_dense0 <= m_dense[0][dense_ram_addr_b];
    q_dense1 <= m_dense[1][dense_ram_addr_b];
    q_dense2 <= m_dense[2][dense_ram_addr_b];
    q_dense3 <= m_dense[3][dense_ram_addr_b];
  end

  task automatic fill(input bit ones);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < IW; i++)
        m_img[b][i] = ones ? 8'h01 : 8'($urandom);
      for (int i = 0; i < DW; i++)
        m_dense[b][i] = ones ? 8'h01 : 8'($urandom);
    end
    for (int i = 0; i < CB; i++)
      m_conv[i] = ones ? 8'h01 : 8'($urandom);
  endtask

  // Expected k-th word of a run: image words, then conv bytes, then
  // dense words, then (optionally) the running sum of all of those.
  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] s;
    s = 32'h0;
    if (k < IW)
      return {m_img[0][k], m_img[1][k], m_img[2][k], m_img[3][k]};
    if (k < IW + CB)
      return {24'h0, m_conv[k - IW]};
    if (k < ND)
      return {m_dense[0][k - IW - CB], m_dense[1][k - IW - CB],
              m_dense[2][k - IW - CB], m_dense[3][k - IW - CB]};
    for (int j = 0; j < ND; j++) s = s + exp_word(j);
    return s;
  endfunction

  task automatic clean_abort;
    control_reg = ABORT;
    rd_ready = 1'b0;
    @(negedge clk);
    control_reg = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    control_reg = 32'h0;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({rd_valid, busy, done} !== 3'b000 || readdata !== 32'h0 ||
        image_ram_addr_b !== 10'h0 || conv_ram_addr_b !== 15'h0 ||
        dense_ram_addr_b !== 15'h0) begin
      errs++;
      $display("FAIL reset: v/b/d=%b data=%h addrs=%0d/%0d/%0d, need all 0",
               {rd_valid, busy, done}, readdata, image_ram_addr_b,
               conv_ram_addr_b, dense_ram_addr_b);
    end
    reset = 1'b0;
    @(negedge clk);
    vec++;
    if ({rd_valid, busy, done} !== 3'b000) begin
      errs++;
      $display("FAIL idle_after_reset: v/b/d=%b need 000",
               {rd_valid, busy, done});
    end
  endtask

  task automatic test_first_word;
    fill(1'b0);
    m_img[0][0] = 8'h11;
    m_img[1][0] = 8'h22;
    m_img[2][0] = 8'h33;
    m_img[3][0] = 8'h44;
    control_reg = START;
    rd_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      control_reg = 32'h0;
      vec++;
      if (rd_valid !== (c == 3)) begin
        errs++;
        $display("FAIL first_latency: cycle %0d rd_valid=%b need %b",
                 c, rd_valid, (c == 3));
      end
    end
    vec++;
    if (readdata !== 32'h11223344) begin
      errs++;
      $display("FAIL first_word: got %h need 11223344", readdata);
    end
    @(negedge clk);
    vec++;
    if (image_ram_addr_b !== 10'd1 || busy !== 1'b1 || rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL next_fetch_addr: addr=%0d busy=%b valid=%b need 1/1/0",
               image_ram_addr_b, busy, rd_valid);
    end
    clean_abort();
  endtask

  task automatic test_full_run(input bit rand_ready, input bit ones,
                               output logic [31:0] last_word);
    int k, cyc, last, nz, gap;
    fill(ones);
    last_word = 32'h0;
    control_reg = START;
    rd_ready = 1'b0;
    @(negedge clk);
    k = 0;
    cyc = 1;
    last = 0;
    while (done !== 1'b1 && cyc < NW * 12 + 50) begin
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      nz = int'(image_ram_addr_b != 0) + int'(conv_ram_addr_b != 0) +
           int'(dense_ram_addr_b != 0);
      vec++;
      if (image_ram_addr_b >= IW || conv_ram_addr_b >= CB ||
          dense_ram_addr_b >= DW || nz > 1 || (rd_valid && !busy)) begin
        errs++;
        $display("FAIL addr_invariant: addrs=%0d/%0d/%0d valid=%b busy=%b",
                 image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b,
                 rd_valid, busy);
      end
      if (rd_valid === 1'b1 && rd_ready) begin
        vec++;
        if (readdata !== exp_word(k)) begin
          errs++;
          $display("FAIL word_data: word %0d got %h need %h",
                   k, readdata, exp_word(k));
        end
        if (!rand_ready) begin
          gap = (k == ND) ? 1 : 3;
          vec++;
          if (cyc - last != gap) begin
            errs++;
            $display("FAIL throughput: word %0d gap %0d need %0d",
                     k, cyc - last, gap);
          end
        end
        last_word = readdata;
        last = cyc;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    vec++;
    if (k != NW || done !== 1'b1) begin
      errs++;
      $display("FAIL run_length: words %0d done=%b need %0d and 1",
               k, done, NW);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec++;
      if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
        errs++;
        $display("FAIL start_hold: d/b/v=%b need 100",
                 {done, busy, rd_valid});
      end
    end
    control_reg = 32'h0;
    @(negedge clk);
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL release_idle: done=%b busy=%b need 0/0", done, busy);
    end
  endtask

  task automatic test_backpressure;
    int k, cyc;
    fill(1'b0);
    control_reg = START;
    rd_ready = 1'b1;
    @(negedge clk);
    control_reg = 32'h0;
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 100) begin
      if (rd_valid === 1'b1) k++;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    while (rd_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    vec++;
    if (rd_valid !== 1'b1 || readdata !== exp_word(5)) begin
      errs++;
      $display("FAIL bp_word5: valid=%b data=%h need 1 %h",
               rd_valid, readdata, exp_word(5));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec++;
      if (rd_valid !== 1'b1 || readdata !== exp_word(5) ||
          image_ram_addr_b !== 10'd5) begin
        errs++;
        $display("FAIL bp_hold: valid=%b data=%h addr=%0d need 1 %h 5",
                 rd_valid, readdata, image_ram_addr_b, exp_word(5));
      end
    end
    rd_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (rd_valid !== 1'b0 || image_ram_addr_b !== 10'd6) begin
      errs++;
      $display("FAIL bp_release: valid=%b addr=%0d need 0 6",
               rd_valid, image_ram_addr_b);
    end
    clean_abort();
  endtask

  task automatic test_abort;
    int k, cyc;
    fill(1'b0);
    control_reg = START;
    rd_ready = 1'b1;
    @(negedge clk);
    control_reg = 32'h0;
    k = 0;
    cyc = 0;
    while (!(rd_valid === 1'b1 && k == IW + 100) && cyc < 2000) begin
      if (rd_valid === 1'b1) k++;
      @(negedge clk);
      cyc++;
    end
    vec++;
    if (rd_valid !== 1'b1 || conv_ram_addr_b !== 15'd100) begin
      errs++;
      $display("FAIL abort_reach: valid=%b conv_addr=%0d need 1 100",
               rd_valid, conv_ram_addr_b);
    end
    control_reg = ABORT;
    @(negedge clk);
    vec++;
    if ({rd_valid, busy, done} !== 3'b000 || image_ram_addr_b !== 10'h0 ||
        conv_ram_addr_b !== 15'h0 || dense_ram_addr_b !== 15'h0) begin
      errs++;
      $display("FAIL abort_idle: v/b/d=%b addrs=%0d/%0d/%0d need 000 0/0/0",
               {rd_valid, busy, done}, image_ram_addr_b,
               conv_ram_addr_b, dense_ram_addr_b);
    end
    control_reg = 32'h0;
    @(negedge clk);
    control_reg = START;
    @(negedge clk);
    control_reg = 32'h0;
    cyc = 0;
    while (rd_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vec++;
    if (rd_valid !== 1'b1 || readdata !== exp_word(0) ||
        image_ram_addr_b !== 10'h0) begin
      errs++;
      $display("FAIL restart: valid=%b data=%h addr=%0d need 1 %h 0",
               rd_valid, readdata, image_ram_addr_b, exp_word(0));
    end
    clean_abort();
  endtask

  task automatic test_reset_mid;
    int cyc;
    fill(1'b0);
    control_reg = START;
    rd_ready = 1'b1;
    @(negedge clk);
    control_reg = 32'h0;
    repeat (5) @(negedge clk);
    rd_ready = 1'b0;
    cyc = 0;
    while (rd_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec++;
    if ({rd_valid, busy, done} !== 3'b000 || readdata !== 32'h0 ||
        image_ram_addr_b !== 10'h0) begin
      errs++;
      $display("FAIL reset_mid: v/b/d=%b data=%h addr=%0d need 000 0 0",
               {rd_valid, busy, done}, readdata, image_ram_addr_b);
    end
    @(negedge clk);
  endtask

`ifdef READBACK_CHECKSUM_EN
  task automatic test_checksum;
    logic [31:0] lw;
    logic [31:0] want;
    want = 32'(IW) * 32'h01010101 + 32'(CB) + 32'(DW) * 32'h01010101;
    test_full_run(1'b0, 1'b1, lw);
    vec++;
    if (lw !== want) begin
      errs++;
      $display("FAIL checksum: got %h need %h", lw, want);
    end
  endtask
`endif

  initial begin
    logic [31:0] lw;
    test_reset();
    test_first_word();
    test_full_run(1'b0, 1'b0, lw);
    test_full_run(1'b1, 1'b0, lw);
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef READBACK_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
